// File: rtl/instr_issue_fifo_pkg.sv
// Shared instruction-format definitions for the fetch front end, the pipeline and the hazard unit.
// Holds the NOP encoding, the opcode constants and the instruction field positions.
package instr_issue_fifo_pkg;

   localparam int          INSTR_W   = 8;
   localparam logic [7:0]  NOP_INSTR = 8'h00;

   localparam logic [2:0]  OP_NOP = 3'b000;
   localparam logic [2:0]  OP_ADD = 3'b001;
   localparam logic [2:0]  OP_INC = 3'b011;

   // {mode[7], opcode[6:4], rd/rs1[3:2], rs2[1:0]}
   localparam int MODE_BIT = 7;
   localparam int OPC_MSB  = 6;
   localparam int OPC_LSB  = 4;
   localparam int RD_MSB   = 3;
   localparam int RD_LSB   = 2;
   localparam int RS2_MSB  = 1;
   localparam int RS2_LSB  = 0;

   function automatic logic [2:0] instr_opcode(input logic [7:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/instr_issue_fifo_rise_detect.sv
// Registered rising-edge detector for slow level inputs such as push keys.
// RESET_VAL = 1 keeps a level already high when reset releases from counting as an edge.
module rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic din,
   output logic pulse
);

   logic din_q_r;

   // Previous-cycle copy of the input level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         din_q_r <= RESET_VAL;
      end else begin
         din_q_r <= din;
      end
   end

   assign pulse = din & ~din_q_r;

endmodule

// File: rtl/instr_issue_fifo.sv
// Instruction queue feeding the fetch stage: key-driven pushes, one issue per cycle,
// the head is held while the hazard unit stalls, and a NOP is driven whenever nothing is queued.
module instr_issue_fifo
   import instr_issue_fifo_pkg::*;
#(
   parameter int IW    = INSTR_W,
   parameter int DEPTH = 8,
   parameter int CW    = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push_req,
   input  logic [IW-1:0]            push_instr,
   input  logic                     run,
   input  logic                     flush,
   input  logic                     stall,
   output logic [IW-1:0]            issue_instr,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [CW-1:0]            issued_cnt
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              NW      = AW + 1;
   localparam logic [NW-1:0]   DEPTH_N = NW'(DEPTH);

   logic [IW-1:0] mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [NW-1:0] count_r;
   logic          overflow_r;
   logic [CW-1:0] issued_cnt_r;

   logic          push_pulse_s;
   logic          full_s;
   logic          empty_s;
   logic          issue_valid_s;
   logic [IW-1:0] issue_instr_s;
   logic          pop_s;
   logic          push_ok_s;

   rise_detect #(.RESET_VAL(1'b1)) u_push_edge (
      .clk    (clk),
      .resetn (resetn),
      .din    (push_req),
      .pulse  (push_pulse_s)
   );

   assign full_s        = (count_r == DEPTH_N);
   assign empty_s       = (count_r == {NW{1'b0}});
   assign issue_valid_s = run & ~empty_s;
   // The head leaves only on the edge where fetch actually latches it
   assign pop_s         = issue_valid_s & ~stall;
   assign push_ok_s     = push_pulse_s & (~full_s | pop_s);

   // Head presentation towards fetch; NOP when idle or held
   always_comb begin
      issue_instr_s = IW'(NOP_INSTR);
      if (issue_valid_s) begin
         issue_instr_s = mem_r[rd_ptr_r];
      end else begin
         issue_instr_s = IW'(NOP_INSTR);
      end
   end

   // Queue control state; flush outranks any push or pop in the same cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_r     <= {AW{1'b0}};
         wr_ptr_r     <= {AW{1'b0}};
         count_r      <= {NW{1'b0}};
         overflow_r   <= 1'b0;
         issued_cnt_r <= {CW{1'b0}};
      end else if (flush) begin
         rd_ptr_r     <= {AW{1'b0}};
         wr_ptr_r     <= {AW{1'b0}};
         count_r      <= {NW{1'b0}};
         overflow_r   <= 1'b0;
         issued_cnt_r <= {CW{1'b0}};
      end else begin
         if (pop_s) begin
            rd_ptr_r     <= rd_ptr_r + AW'(1);
            issued_cnt_r <= issued_cnt_r + CW'(1);
         end
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (push_pulse_s & full_s & ~pop_s) begin
            overflow_r <= 1'b1;
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + NW'(1);
            2'b01:   count_r <= count_r - NW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are only ever observed behind issue_valid, so no reset
   always_ff @(posedge clk) begin
      if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= push_instr;
      end
   end

   assign issue_instr = issue_instr_s;
   assign issue_valid = issue_valid_s;
   assign count       = count_r;
   assign full        = full_s;
   assign empty       = empty_s;
   assign overflow    = overflow_r;
   assign issued_cnt  = issued_cnt_r;

endmodule

// File: tb/tb_instr_issue_fifo.sv
// Self-checking bench for instr_issue_fifo: table-driven vectors, directed corner sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_instr_issue_fifo;

   localparam int DEPTH = 8;
   localparam int IW    = 8;
   localparam int CW    = 16;
   localparam int NW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          push_req;
   logic [IW-1:0] push_instr;
   logic          run;
   logic          flush;
   logic          stall;
   logic [IW-1:0] issue_instr;
   logic          issue_valid;
   logic [NW-1:0] count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [CW-1:0] issued_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [IW-1:0] mq[$];
   logic          m_prev;
   logic          m_ovf;
   int            m_issued;

   typedef struct {
      logic          pr;
      logic [IW-1:0] ins;
      logic          rn;
      logic          st;
      int            e_count;
      logic          e_valid;
      logic [IW-1:0] e_instr;
      int            e_issued;
   } vec_t;

   vec_t tbl[10];

   instr_issue_fifo #(.IW(IW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .push_req    (push_req),
      .push_instr  (push_instr),
      .run         (run),
      .flush       (flush),
      .stall       (stall),
      .issue_instr (issue_instr),
      .issue_valid (issue_valid),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow),
      .issued_cnt  (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs and compare every output with the model
   task automatic apply(input logic pr, input logic [IW-1:0] ins, input logic rn,
                        input logic fl, input logic st);
      logic          ev;
      logic [IW-1:0] ei;
      push_req = pr; push_instr = ins; run = rn; flush = fl; stall = st;
      #2;
      ev = rn && (mq.size() > 0);
      ei = ev ? mq[0] : 8'h00;
      chk("issue_valid", 32'(issue_valid), 32'(ev));
      chk("issue_instr", 32'(issue_instr), 32'(ei));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
      chk("count_bound", 32'(count <= NW'(DEPTH)), 32'd1);
   endtask

   // Advance the model by the clock edge and move to just after it
   task automatic advance();
      logic          pulse;
      logic          was_full;
      logic          pop;
      logic [IW-1:0] dummy;
      pulse  = push_req && !m_prev;
      m_prev = push_req;
      if (flush) begin
         mq.delete();
         m_ovf    = 1'b0;
         m_issued = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = run && (mq.size() > 0) && !stall;
         if (pop) begin
            dummy    = mq.pop_front();
            m_issued = (m_issued + 1) % 65536;
         end
         if (pulse) begin
            if (!was_full || pop) mq.push_back(push_instr);
            else                  m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic pr, input logic [IW-1:0] ins, input logic rn,
                        input logic fl, input logic st);
      apply(pr, ins, rn, fl, st);
      advance();
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      run    = 1'b1;
      flush  = 1'b0;
      stall  = 1'b0;
      resetn = 1'b0;
      #2;
      mq.delete();
      m_prev   = 1'b1;
      m_ovf    = 1'b0;
      m_issued = 0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_issue_instr", 32'(issue_instr), 32'h00);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic push_one(input logic [IW-1:0] v, input logic rn);
      cycle(1'b1, v, rn, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, rn, 1'b0, 1'b0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'h17, 1'b0, 1'b0, 0, 1'b0, 8'h00, 0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h00, 0};
      tbl[2] = '{1'b1, 8'h2C, 1'b0, 1'b0, 1, 1'b0, 8'h00, 0};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 8'h00, 0};
      tbl[4] = '{1'b1, 8'h31, 1'b0, 1'b0, 2, 1'b0, 8'h00, 0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00, 0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h17, 0};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h2C, 1};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h31, 2};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 3};

      push_req = 1'b1; push_instr = 8'h00; run = 1'b0; flush = 1'b0; stall = 1'b0;
      resetn = 1'b1;
      #3;

      // 1: key held through reset must not enqueue
      do_reset();
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("t1_held_key_no_push", 32'(count), 32'd0);
      cycle(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("t1_repress_push", 32'(count), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 2: table-driven run=0 fill, then consecutive issue
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].pr, tbl[i].ins, tbl[i].rn, 1'b0, tbl[i].st);
         chk($sformatf("t2_count[%0d]", i), 32'(count), 32'(tbl[i].e_count));
         chk($sformatf("t2_valid[%0d]", i), 32'(issue_valid), 32'(tbl[i].e_valid));
         chk($sformatf("t2_instr[%0d]", i), 32'(issue_instr), 32'(tbl[i].e_instr));
         chk($sformatf("t2_issued[%0d]", i), 32'(issued_cnt), 32'(tbl[i].e_issued));
         advance();
      end

      // 3: stall holds the head
      push_one(8'h17, 1'b0);
      push_one(8'h2C, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         chk("t3_stall_head", 32'(issue_instr), 32'h17);
         chk("t3_stall_count", 32'(count), 32'd2);
         advance();
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t3_after_stall", 32'(issue_instr), 32'h2C);
      advance();

      // 4: fill, overflow, push-with-pop when full
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) push_one(8'(8'h40 + i), 1'b0);
      chk("t4_full", 32'(full), 32'd1);
      push_one(8'hEE, 1'b0);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_count8", 32'(count), 32'd8);
      cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      chk("t4_push_pop_full", 32'(count), 32'd8);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);

      // 5: pointer wrap through 20 push/pop pairs
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) push_one(8'($urandom_range(1, 255)), 1'b1);
      chk("t5_final_count", 32'(count), 32'd0);

      // 6: flush with 5 queued and overflow set
      for (int i = 0; i < DEPTH + 1; i++) push_one(8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t6_pre_count", 32'(count), 32'd5);
      chk("t6_pre_ovf", 32'(overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_overflow", 32'(overflow), 32'd0);
      chk("t6_issued", 32'(issued_cnt), 32'd0);
      chk("t6_instr", 32'(issue_instr), 32'h00);
      advance();

      // Randomized traffic with occasional flush and mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 79) == 0),
                  1'($urandom_range(0, 3) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
